// File: rtl/dmem_ctrl.sv
// Byte-addressed RV32 data memory: request/response handshake, sized loads/stores,
// fault detection, wait states and a post-reset clear. Optional counters: DMEM_STATS_EN.
module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_fault,
`ifdef DMEM_STATS_EN
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_faults,
`endif
    output logic              init_busy
);
    localparam int unsigned IW = $clog2(DEPTH_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH_WORDS - 1);
    localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH_WORDS);
    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] clr_q, clr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic              accept;
    logic [ADDR_W-3:0] widx;
    logic [IW-1:0]     midx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_ext;
    logic [31:0]       st_word;
    logic              bad_size, misalign, out_range, fault;
    logic              mem_we;
    logic [IW-1:0]     mem_waddr;
    logic [31:0]       mem_wdata;

    assign accept    = req_valid && (state_q == S_IDLE);
    assign widx      = req_addr[ADDR_W-1:2];
    assign midx      = widx[IW-1:0];
    assign lane      = req_addr[1:0];
    assign rd_word   = mem_q[midx];
    assign out_range = (widx >= DEPTH_L);
    assign fault     = out_range || misalign || bad_size;

    always_comb begin
        bad_size = 1'b0;
        misalign = 1'b0;
        case (req_size)
            3'b000:         ;
            3'b100:         bad_size = req_we;
            3'b001:         misalign = req_addr[0];
            3'b101:         begin misalign = req_addr[0]; bad_size = req_we; end
            3'b010:         misalign = (lane != 2'b00);
            default:        bad_size = 1'b1;
        endcase
    end

    always_comb begin
        case (lane)
            2'd0:    ld_byte = rd_word[7:0];
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (req_size)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = rd_word;
        endcase
    end

    // Stores are a read-modify-write of the addressed word so untouched lanes survive.
    always_comb begin
        st_word = rd_word;
        case (req_size[1:0])
            2'b00: begin
                case (lane)
                    2'd0:    st_word[7:0]   = req_wdata[7:0];
                    2'd1:    st_word[15:8]  = req_wdata[7:0];
                    2'd2:    st_word[23:16] = req_wdata[7:0];
                    default: st_word[31:24] = req_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (req_addr[1]) st_word[31:16] = req_wdata[15:0];
                else             st_word[15:0]  = req_wdata[15:0];
            end
            default: st_word = req_wdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        mem_we    = 1'b0;
        mem_waddr = midx;
        mem_wdata = st_word;
        case (state_q)
            S_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_q;
                mem_wdata = '0;
                if (clr_q == LAST_IDX) begin
                    clr_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    fault_d = fault;
                    rdata_d = (fault || req_we) ? '0 : ld_ext;
                    mem_we  = req_we && !fault;
                    cnt_d   = '0;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == WS_LAST) state_d = S_RESP;
                else                  cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            clr_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;
    assign init_busy = (state_q == S_INIT);

`ifdef DMEM_STATS_EN
    logic [31:0] loads_q, stores_q, faults_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            loads_q  <= '0;
            stores_q <= '0;
            faults_q <= '0;
        end else if (accept) begin
            if (fault)       faults_q <= faults_q + 1'b1;
            else if (req_we) stores_q <= stores_q + 1'b1;
            else             loads_q  <= loads_q + 1'b1;
        end
    end
    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_faults = faults_q;
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with no wait states, one with three.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'b010;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        ready0, rv0, flt0, busy0;
    logic        ready3, rv3, flt3, busy3;
    logic [31:0] rd0, rd3;
    logic        ready_m, rv_m, flt_m, busy_m;
    logic [31:0] rd_m;

    int errors = 0;
    int checks = 0;

`ifdef DMEM_STATS_EN
    logic [31:0] sl0, ss0, sf0, sl3, ss3, sf3;
`endif

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(ready0),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_fault(flt0),
`ifdef DMEM_STATS_EN
        .stat_loads(sl0), .stat_stores(ss0), .stat_faults(sf0),
`endif
        .init_busy(busy0));

    dmem_ctrl #(.DEPTH_WORDS(256), .ADDR_W(32), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(ready3),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_fault(flt3),
`ifdef DMEM_STATS_EN
        .stat_loads(sl3), .stat_stores(ss3), .stat_faults(sf3),
`endif
        .init_busy(busy3));

    assign ready_m = sel ? ready3 : ready0;
    assign rv_m    = sel ? rv3 : rv0;
    assign flt_m   = sel ? flt3 : flt0;
    assign busy_m  = sel ? busy3 : busy0;
    assign rd_m    = sel ? rd3 : rd0;

    // Issues one access; lat is the number of cycles from the accept cycle to rsp_valid.
    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic flt, output int lat);
        int n;
        n = 0;
        while (!ready_m && n < 1000) begin @(posedge clk); #1; n++; end
        checks++;
        if (ready_m !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout addr=%h got ready=%b want 1", a, ready_m);
        end
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rv_m && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++;
        if (rv_m !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout addr=%h got rsp_valid=%b want 1", a, rv_m);
        end
        rd = rd_m;
        flt = flt_m;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // Counts init_busy cycles starting at the current sample point; also flags any ready.
    task automatic count_init(output int cnt, output logic saw_ready);
        cnt = 0;
        saw_ready = 1'b0;
        while (busy_m && cnt < 2000) begin
            if (ready_m) saw_ready = 1'b1;
            cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int cnt;
        logic sr;
        logic [31:0] rd;
        logic flt;
        int lat;
        sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want 0", ready0); end
        checks++; if (rv0 !== 1'b0)    begin errors++; $display("FAIL rst_rsp_valid got=%b want 0", rv0); end
        checks++; if (rd0 !== 32'h0)   begin errors++; $display("FAIL rst_rdata got=%h want 0", rd0); end
        checks++; if (flt0 !== 1'b0)   begin errors++; $display("FAIL rst_fault got=%b want 0", flt0); end
        checks++; if (busy0 !== 1'b1)  begin errors++; $display("FAIL rst_init_busy got=%b want 1", busy0); end
        count_init(cnt, sr);
        checks++; if (cnt != 256) begin errors++; $display("FAIL init_cycles got=%0d want 256", cnt); end
        checks++; if (sr !== 1'b0) begin errors++; $display("FAIL init_ready got=%b want 0", sr); end
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL post_init_ready got=%b want 1", ready0); end
        access(1'b0, 3'b010, 32'h3FC, '0, rd, flt, lat);
        chk32("lw_3fc_data", rd, 32'h0);
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL lw_3fc_fault got=%b want 0", flt); end
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic flt;
        int lat;
        sel = 1'b0;
        access(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, rd, flt, lat);
        chk32("sw_rdata_zero", rd, 32'h0);
        checks++; if (lat != 1) begin errors++; $display("FAIL sw_latency got=%0d want 1", lat); end
        access(1'b0, 3'b010, 32'h8, '0, rd, flt, lat);
        chk32("lw_8", rd, 32'hDEADBEEF);
        checks++; if (lat != 1) begin errors++; $display("FAIL lw_latency got=%0d want 1", lat); end
        @(posedge clk); #1;
        checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL rsp_pulse got=%b want 0", rv0); end
        chk32("rdata_hold", rd0, 32'hDEADBEEF);
    endtask

    task automatic test_subword();
        logic [31:0] rd;
        logic flt;
        int lat;
        sel = 1'b0;
        access(1'b0, 3'b000, 32'h8, '0, rd, flt, lat); chk32("lb_8", rd, 32'hFFFFFFEF);
        access(1'b0, 3'b100, 32'hB, '0, rd, flt, lat); chk32("lbu_b", rd, 32'h000000DE);
        access(1'b0, 3'b001, 32'hA, '0, rd, flt, lat); chk32("lh_a", rd, 32'hFFFFDEAD);
        access(1'b0, 3'b101, 32'h8, '0, rd, flt, lat); chk32("lhu_8", rd, 32'h0000BEEF);
        access(1'b1, 3'b000, 32'h9, 32'hFFFFFF55, rd, flt, lat);
        access(1'b1, 3'b001, 32'hA, 32'hABCD1234, rd, flt, lat);
        access(1'b0, 3'b010, 32'h8, '0, rd, flt, lat); chk32("merge_lw_8", rd, 32'h123455EF);
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic flt;
        int lat;
        sel = 1'b0;
        access(1'b0, 3'b010, 32'h6, '0, rd, flt, lat);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL lw_6_fault got=%b want 1", flt); end
        chk32("lw_6_rdata", rd, 32'h0);
        access(1'b1, 3'b001, 32'h5, 32'h0000FFFF, rd, flt, lat);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL sh_5_fault got=%b want 1", flt); end
        access(1'b0, 3'b010, 32'h4, '0, rd, flt, lat);
        chk32("lw_4_unchanged", rd, 32'h0);
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL lw_4_fault got=%b want 0", flt); end
        access(1'b0, 3'b010, 32'h400, '0, rd, flt, lat);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL lw_400_fault got=%b want 1", flt); end
        access(1'b0, 3'b011, 32'h8, '0, rd, flt, lat);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL size011_fault got=%b want 1", flt); end
        chk32("size011_rdata", rd, 32'h0);
        access(1'b1, 3'b100, 32'h8, 32'h0, rd, flt, lat);
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL sbu_store_fault got=%b want 1", flt); end
        access(1'b0, 3'b010, 32'h8, '0, rd, flt, lat);
        chk32("lw_8_after_faults", rd, 32'h123455EF);
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic flt;
        int lat;
        sel = 1'b1;
        access(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, rd, flt, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL ws3_sw_latency got=%0d want 4", lat); end
        access(1'b0, 3'b010, 32'h10, '0, rd, flt, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL ws3_lw_latency got=%0d want 4", lat); end
        chk32("ws3_lw_10", rd, 32'hCAFEF00D);
    endtask

    task automatic test_reset_inflight();
        int cnt;
        logic sr;
        logic saw_rsp;
        logic [31:0] rd;
        logic flt;
        int lat;
        sel = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rv3) saw_rsp = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw_rsp !== 1'b0) begin errors++; $display("FAIL inflight_rsp got=%b want 0", saw_rsp); end
        count_init(cnt, sr);
        cnt = cnt + 8;
        checks++; if (cnt != 256) begin errors++; $display("FAIL reinit_cycles got=%0d want 256", cnt); end
        access(1'b0, 3'b010, 32'h10, '0, rd, flt, lat);
        chk32("store_wiped", rd, 32'h0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_faults();
        test_wait_states();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
